// File: rtl/chanx_bist_pkg.sv
// rtl/chanx_bist_pkg.sv - shared types and constants for the chanx BIST engine
package chanx_bist_pkg;

    localparam int CHAN_WIDTH_DEF = 64;
    localparam int LAT_MAX_DEF    = 15;

    // Taps for x^32 + x^22 + x^2 + x + 1 on a left-shifting Fibonacci register
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_WALK,
        MODE_CHECKER,
        MODE_LFSR,
        MODE_TOGGLE
    } mode_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/chanx_bist_engine_if.sv
// rtl/chanx_bist_engine_if.sv - control, status and channel bundle of the BIST engine
interface chanx_bist_engine_if
    import chanx_bist_pkg::*;
#(
    parameter int CHAN_WIDTH = CHAN_WIDTH_DEF
);
    logic                  start;
    logic                  abort;
    logic [1:0]            mode;
    logic [15:0]           len_cfg;
    logic [3:0]            lat_cfg;
    logic [0:CHAN_WIDTH-1] chanx_drive_out;
    logic [0:CHAN_WIDTH-1] chanx_sample_in;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           err_count;
    logic [15:0]           first_err_beat;
    logic [5:0]            first_err_track;

    modport master (
        output start, abort, mode, len_cfg, lat_cfg, chanx_sample_in,
        input  chanx_drive_out, busy, done, pass, err_count, first_err_beat, first_err_track
    );

    modport slave (
        input  start, abort, mode, len_cfg, lat_cfg, chanx_sample_in,
        output chanx_drive_out, busy, done, pass, err_count, first_err_beat, first_err_track
    );
endinterface

// File: rtl/chanx_bist_patgen.sv
// rtl/chanx_bist_patgen.sv - registered track pattern generator, one beat per strobe
module chanx_bist_patgen
    import chanx_bist_pkg::*;
#(
    parameter int CHAN_WIDTH = CHAN_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_adv,
    input  logic [1:0]            i_mode,
    output logic [0:CHAN_WIDTH-1] o_pattern
);
    localparam int WW = (CHAN_WIDTH > 1) ? $clog2(CHAN_WIDTH) : 1;

    // r_walk/r_odd/r_lfsr describe the beat that will be emitted on the next strobe
    mode_e                 r_mode;
    logic [WW-1:0]         r_walk;
    logic                  r_odd;
    logic [31:0]           r_lfsr;
    logic [0:CHAN_WIDTH-1] r_pat;

    mode_e                 w_mode;
    logic [WW-1:0]         w_walk;
    logic                  w_odd;
    logic [31:0]           w_lfsr;
    logic [63:0]           w_lfsr64;
    logic [0:CHAN_WIDTH-1] w_pat;

    // Build the pattern for the beat about to be registered; a load restarts at beat 0
    always_comb begin
        w_mode   = i_load ? mode_e'(i_mode) : r_mode;
        w_walk   = i_load ? '0 : r_walk;
        w_odd    = i_load ? 1'b0 : r_odd;
        w_lfsr   = i_load ? LFSR_SEED : r_lfsr;
        w_lfsr64 = {w_lfsr, ~w_lfsr};
        w_pat    = '0;
        for (int i = 0; i < CHAN_WIDTH; i++) begin
            case (w_mode)
                MODE_WALK:    w_pat[i] = (i == int'(w_walk));
                MODE_CHECKER: w_pat[i] = i[0] ^ w_odd;
                MODE_LFSR:    if (i < 64) w_pat[i] = w_lfsr64[6'(63 - i)];
                default:      w_pat[i] = ~w_odd;
            endcase
        end
    end

    // Register the beat and step the sequence state; drop to all-zero between tests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= MODE_WALK;
            r_walk <= '0;
            r_odd  <= 1'b0;
            r_lfsr <= LFSR_SEED;
            r_pat  <= '0;
        end else if (i_load || i_adv) begin
            r_mode <= w_mode;
            r_pat  <= w_pat;
            r_walk <= (w_walk == WW'(CHAN_WIDTH - 1)) ? '0 : w_walk + 1'b1;
            r_odd  <= ~w_odd;
            r_lfsr <= lfsr_next(w_lfsr);
        end else begin
            r_pat  <= '0;
        end
    end

    assign o_pattern = r_pat;

endmodule

// File: rtl/chanx_bist_engine.sv
// rtl/chanx_bist_engine.sv - channel BIST top: FSM, expected-value delay line, compare, results
module chanx_bist_engine
    import chanx_bist_pkg::*;
#(
    parameter int CHAN_WIDTH = CHAN_WIDTH_DEF,
    parameter int LAT_MAX    = LAT_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    chanx_bist_engine_if.slave bus
);
    state_e                r_state;
    state_e                w_next;
    logic [15:0]           r_len;
    logic [15:0]           r_beat;
    logic [3:0]            r_lat;
    logic [3:0]            r_drain;
    logic [15:0]           r_cmp_beat;
    logic [15:0]           r_err;
    logic [15:0]           r_first_beat;
    logic [5:0]            r_first_trk;
    logic                  r_pass;
    logic [0:CHAN_WIDTH-1] r_dl_data [1:LAT_MAX];
    logic [LAT_MAX:1]      r_dl_vld;

    logic                  w_accept;
    logic [3:0]            w_lat_clamp;
    logic                  w_last_beat;
    logic                  w_busy;
    logic                  w_done;
    logic [0:CHAN_WIDTH-1] w_pattern;
    logic [0:CHAN_WIDTH-1] w_tap_data;
    logic                  w_tap_vld;
    logic                  w_cmp_en;
    logic [0:CHAN_WIDTH-1] w_diff;
    logic                  w_mismatch;
    logic [5:0]            w_low_trk;
    logic [15:0]           w_err_next;

    assign w_accept    = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_lat_clamp = (int'(bus.lat_cfg) > LAT_MAX) ? 4'(LAT_MAX) : bus.lat_cfg;
    assign w_last_beat = (r_beat == r_len - 16'd1);

    // Next-state and status decode; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = (bus.len_cfg == 16'd0) ? ST_DONE : ST_DRIVE;
            end
            ST_DRIVE: begin
                w_busy = 1'b1;
                if (w_last_beat) w_next = (r_lat == 4'd0) ? ST_DONE : ST_DRAIN;
            end
            ST_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain == 4'd0) w_next = ST_DONE;
            end
            default: begin
                w_done = 1'b1;
                w_next = ST_IDLE;
            end
        endcase
        if (bus.abort) w_next = ST_IDLE;
    end

    // State register plus the per-test configuration and beat/drain counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_lat   <= '0;
            r_beat  <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_len  <= bus.len_cfg;
                r_lat  <= w_lat_clamp;
                r_beat <= '0;
            end else if (r_state == ST_DRIVE) begin
                r_beat <= r_beat + 16'd1;
            end
            if (r_state == ST_DRIVE && w_next == ST_DRAIN) begin
                r_drain <= r_lat - 4'd1;
            end else if (r_state == ST_DRAIN) begin
                r_drain <= r_drain - 4'd1;
            end
        end
    end

    chanx_bist_patgen #(
        .CHAN_WIDTH (CHAN_WIDTH)
    ) u_patgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept && (bus.len_cfg != 16'd0)),
        .i_adv     ((r_state == ST_DRIVE) && (w_next == ST_DRIVE)),
        .i_mode    (bus.mode),
        .o_pattern (w_pattern)
    );

    // Valid flags of the expected-value delay line; start and abort flush them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_vld <= '0;
        end else if (w_accept || bus.abort) begin
            r_dl_vld <= '0;
        end else begin
            r_dl_vld[1] <= (r_state == ST_DRIVE);
            for (int i = 2; i <= LAT_MAX; i++) r_dl_vld[i] <= r_dl_vld[i-1];
        end
    end

    // Expected data shifts freely; only the valid flags decide whether a stage matters
    always_ff @(posedge clk) begin
        r_dl_data[1] <= w_pattern;
        for (int i = 2; i <= LAT_MAX; i++) r_dl_data[i] <= r_dl_data[i-1];
    end

    // Tap the delay line and find the lowest differing track of the current compare
    always_comb begin
        w_tap_data = w_pattern;
        w_tap_vld  = (r_state == ST_DRIVE);
        if (r_lat != 4'd0) begin
            w_tap_data = r_dl_data[r_lat];
            w_tap_vld  = r_dl_vld[r_lat];
        end
        w_cmp_en   = w_tap_vld && w_busy;
        w_diff     = w_tap_data ^ bus.chanx_sample_in;
        w_mismatch = w_cmp_en && (|w_diff);
        w_low_trk  = '0;
        for (int i = CHAN_WIDTH - 1; i >= 0; i--) begin
            if (w_diff[i]) w_low_trk = 6'(i);
        end
        w_err_next = r_err;
        if (w_mismatch && r_err != 16'hFFFF) w_err_next = r_err + 16'd1;
    end

    // Result registers: cleared by an accepted start, frozen by abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmp_beat   <= '0;
            r_err        <= '0;
            r_first_beat <= '0;
            r_first_trk  <= '0;
            r_pass       <= 1'b0;
        end else if (w_accept) begin
            r_cmp_beat   <= '0;
            r_err        <= '0;
            r_first_beat <= '0;
            r_first_trk  <= '0;
            r_pass       <= (bus.len_cfg == 16'd0);
        end else if (!bus.abort) begin
            if (w_cmp_en) r_cmp_beat <= r_cmp_beat + 16'd1;
            if (w_mismatch) begin
                r_err <= w_err_next;
                if (r_err == 16'd0) begin
                    r_first_beat <= r_cmp_beat;
                    r_first_trk  <= w_low_trk;
                end
            end
            if (w_busy && w_next == ST_DONE) r_pass <= (w_err_next == 16'd0);
        end
    end

    assign bus.chanx_drive_out = w_pattern;
    assign bus.busy            = w_busy;
    assign bus.done            = w_done;
    assign bus.pass            = r_pass;
    assign bus.err_count       = r_err;
    assign bus.first_err_beat  = r_first_beat;
    assign bus.first_err_track = r_first_trk;

endmodule

// File: doc/chanx_bist_engine.md
# chanx_bist_engine

Built-in self-test engine for the horizontal routing channel of one tile row. It is the driving and checking end of the channel that pass-through tiles such as the EMPTY connection-box tile carry. It generates track patterns onto the channel's right-side inputs, samples the channel's left-side outputs after a programmable latency, and reports pass/fail, error count and first-error location. It sits at the fabric periphery and is enabled only in test mode.

## Interface
- `CHAN_WIDTH`, default 64: number of channel tracks.
- `LAT_MAX`, default 15: largest supported drive-to-sample latency, in cycles.
- `clk`, input, 1: test clock, rising-edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `start`, input, 1: single-cycle request; honoured only in IDLE.
- `abort`, input, 1: stops the test; the engine returns to IDLE with no `done`.
- `mode`, input, 2: pattern select, sampled at `start`.
- `len_cfg`, input, 16: number of beats, sampled at `start`.
- `lat_cfg`, input, 4: drive-to-sample latency, sampled at `start`. Valid range is 0..LAT_MAX; 0 means a combinational channel.
- `chanx_drive_out`, output, [0:CHAN_WIDTH-1]: drives the tile's `chanx_right_in`.
- `chanx_sample_in`, input, [0:CHAN_WIDTH-1]: taken from the tile's `chanx_left_out`.
- `busy`, output, 1: high while in DRIVE or DRAIN.
- `done`, output, 1: one-cycle completion pulse.
- `pass`, output, 1: high when the last completed test had zero errors.
- `err_count`, output, 16: number of mismatching beats, saturating at 0xFFFF.
- `first_err_beat`, output, 16: beat index of the first mismatch.
- `first_err_track`, output, 6: lowest mismatching track index within that beat.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
  - IDLE to DRIVE on `start` when `len_cfg` is nonzero.
  - IDLE to DONE on `start` when `len_cfg` is 0. The result is pass=1 and err_count=0.
  - DRIVE to DRAIN after the last beat. DRIVE goes straight to DONE when `lat_cfg` is 0.
  - DRAIN to DONE after the last compare.
  - DONE to IDLE unconditionally, after one cycle.
  - `abort` from any state goes to IDLE. Result registers keep their prior values.
- Pattern modes. `k` is the beat index, 0..len-1.
  - Mode 0, walking one: only track k mod CHAN_WIDTH is high.
  - Mode 1, checkerboard: even beats drive 0101… (track 0 low); odd beats drive the inverse.
  - Mode 2, LFSR: a 32-bit Fibonacci LFSR with polynomial x^32+x^22+x^2+x+1 and seed 0xACE10001. Tracks 0..31 carry the LFSR state MSB-first; tracks 32..63 carry its bitwise inverse. The LFSR advances once per beat.
  - Mode 3, full toggle: even beats drive all ones; odd beats drive all zeros.
- The expected value and a valid flag travel through a delay line of depth LAT_MAX+1, tapped at `lat_cfg`. A compare happens only when the tapped valid flag is high.
- On a mismatch:
  - `err_count` increments, saturating at 0xFFFF.
  - On the first mismatch only, `first_err_beat` and `first_err_track` are captured. `first_err_track` is the lowest index among the differing tracks.
- `start` clears `err_count`, `pass`, `first_err_*` and the delay-line valid flags.
- `chanx_drive_out` is all-zero whenever the engine is not in DRIVE.
- Reset values, for all outputs: `chanx_drive_out` 0, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `first_err_beat` 0, `first_err_track` 0.
- Reset mid-test takes effect immediately. No `done` is produced.
- `start` while `busy` is ignored. `start` and `abort` asserted together resolve as `abort`.
- `lat_cfg` values above LAT_MAX are clamped to LAT_MAX.

## Timing
- With `start` high in IDLE at cycle t, beat k is registered on `chanx_drive_out` at cycle t+1+k.
- The sample for beat k is compared on the rising edge that ends cycle t+1+k+`lat_cfg`.
- `done` is high at cycle t+1+len+lat. At that cycle `pass`, `err_count` and `first_err_*` hold their final values, and they stay stable until the next `start`.
- `busy` is high from cycle t+1 through cycle t+len+lat.
- With `len_cfg` 0, `done` is high at t+1.
- Throughput is one beat per cycle, with no bubbles.

## Structure
- Package `chanx_bist_pkg` holds:
  - the state enum;
  - the mode enum;
  - the LFSR polynomial mask and seed constants;
  - the default CHAN_WIDTH and LAT_MAX values.
- Sub-module `chanx_bist_patgen` generates the pattern. It takes the mode, a beat-index advance strobe and a load strobe, and outputs the pattern for the current beat. The top level contains the FSM, the delay line, the comparator and the result registers.

## Test plan
- Loopback with `lat_cfg` 0, mode 0, `len_cfg` 128, sample tied to drive: `done` at t+129, pass=1, err_count=0, and track 5 is high only on beats 5 and 69.
- Model a 3-cycle register chain, `lat_cfg` 3, mode 2, `len_cfg` 1000: pass=1, `done` at t+1004, and beat 0 drives 0xACE10001 on tracks 0..31.
- Same setup, with track 17 forced to 0 from beat 40 onward in mode 3: err_count=480, first_err_beat=40, first_err_track=17, pass=0.
- `start` with `len_cfg` 0: `done` at t+1, pass=1, `busy` never asserted.
- `abort` at beat 10 of a 100-beat test, then `start` while busy: no `done` and the engine returns to IDLE. A later `start` runs cleanly.
- Assert `rst_n` low mid-DRAIN: all outputs are 0 within the same cycle, and a subsequent test passes.
